// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register address width, forwarding select codes.
package pipeline_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/dest_stage_reg.sv
// One pipeline stage register for a destination register number plus control flags.
// Updates one cycle after capture; hold freezes contents, flush loads a bubble.
module dest_stage_reg
   import pipeline_pkg::*;
#(
   parameter int NFLAGS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] in_wreg,
   input  logic [NFLAGS-1:0]     in_flags,
   output logic [REG_ADDR_W-1:0] out_wreg,
   output logic [NFLAGS-1:0]     out_flags
);

   logic [REG_ADDR_W-1:0] wreg_d, wreg_q;
   logic [NFLAGS-1:0]     flags_d, flags_q;

   // A flush arriving during hold is ignored; upstream keeps it asserted until hold drops.
   always_comb begin
      wreg_d  = wreg_q;
      flags_d = flags_q;
      if (!hold) begin
         if (flush) begin
            wreg_d  = REG_ZERO;
            flags_d = '0;
         end else begin
            wreg_d  = in_wreg;
            flags_d = in_flags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wreg_q  <= REG_ZERO;
         flags_q <= '0;
      end else begin
         wreg_q  <= wreg_d;
         flags_q <= flags_d;
      end
   end

   assign out_wreg  = wreg_q;
   assign out_flags = flags_q;

endmodule

// File: rtl/dest_forward_unit.sv
// Tracks the EX destination through EX/MEM and MEM/WB, driving write-back, ALU forwarding and load-use stall.
// Stage outputs lag EX by 1/2 cycles; forwarding selects and stall are combinational.
module dest_forward_unit
   import pipeline_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hold,
   input  logic                  ex_flush,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] ex_rs,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic [REG_ADDR_W-1:0] ex_wreg,
   input  logic                  ex_regwrite,
   input  logic                  ex_memread,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  load_use_stall,
   output logic [REG_ADDR_W-1:0] mem_wreg,
   output logic                  mem_regwrite,
   output logic                  mem_memread,
   output logic [REG_ADDR_W-1:0] wb_wreg,
   output logic                  wb_regwrite
);

   dest_stage_reg #(.NFLAGS(2)) u_ex_mem (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .flush     (ex_flush),
      .in_wreg   (ex_wreg),
      .in_flags  ({ex_regwrite, ex_memread}),
      .out_wreg  (mem_wreg),
      .out_flags ({mem_regwrite, mem_memread})
   );

   dest_stage_reg #(.NFLAGS(1)) u_mem_wb (
      .clk       (clk),
      .reset     (reset),
      .hold      (hold),
      .flush     (1'b0),
      .in_wreg   (mem_wreg),
      .in_flags  (mem_regwrite),
      .out_wreg  (wb_wreg),
      .out_flags (wb_regwrite)
   );

   // The younger MEM producer wins over WB; $0 is hardwired and never forwarded.
   function automatic logic [1:0] fwd_select(input logic [REG_ADDR_W-1:0] src);
      logic [1:0] sel;
      sel = FWD_RF;
      if (src != REG_ZERO) begin
         if (mem_regwrite && (mem_wreg == src))
            sel = FWD_MEM;
         else if (wb_regwrite && (wb_wreg == src))
            sel = FWD_WB;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a = fwd_select(ex_rs);
      fwd_b = fwd_select(ex_rt);
   end

   always_comb begin
      load_use_stall = ex_memread && ex_regwrite && (ex_wreg != REG_ZERO) &&
                       ((ex_wreg == id_rs) || (ex_wreg == id_rt));
   end

endmodule

// File: tb/tb_dest_forward_unit.sv
// Randomized and directed bench for dest_forward_unit against a stage-list reference model.
module tb_dest_forward_unit;
   import pipeline_pkg::*;

   logic       clk = 1'b0;
   logic       reset, hold, ex_flush;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg;
   logic       ex_regwrite, ex_memread;
   logic [1:0] fwd_a, fwd_b;
   logic       load_use_stall;
   logic [4:0] mem_wreg, wb_wreg;
   logic       mem_regwrite, mem_memread, wb_regwrite;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0] wreg;
      logic       rw;
      logic       mr;
   } stage_t;

   // Index 0 is the MEM stage (youngest), index 1 the WB stage.
   stage_t pipe [2];

   always #5 clk = ~clk;

   dest_forward_unit dut (
      .clk            (clk),
      .reset          (reset),
      .hold           (hold),
      .ex_flush       (ex_flush),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .ex_rs          (ex_rs),
      .ex_rt          (ex_rt),
      .ex_wreg        (ex_wreg),
      .ex_regwrite    (ex_regwrite),
      .ex_memread     (ex_memread),
      .fwd_a          (fwd_a),
      .fwd_b          (fwd_b),
      .load_use_stall (load_use_stall),
      .mem_wreg       (mem_wreg),
      .mem_regwrite   (mem_regwrite),
      .mem_memread    (mem_memread),
      .wb_wreg        (wb_wreg),
      .wb_regwrite    (wb_regwrite)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Youngest writer of src wins; register 0 never matches.
   function automatic logic [1:0] ref_fwd(input logic [4:0] src);
      logic [1:0] code [2];
      code[0] = 2'b10;
      code[1] = 2'b01;
      for (int i = 0; i < 2; i++)
         if (src != 5'd0 && pipe[i].rw && pipe[i].wreg == src)
            return code[i];
      return 2'b00;
   endfunction

   function automatic logic ref_stall();
      return ex_memread && ex_regwrite && ex_wreg != 5'd0 &&
             (ex_wreg == id_rs || ex_wreg == id_rt);
   endfunction

   task automatic model_update();
      stage_t bubble;
      bubble = '0;
      if (reset) begin
         pipe[0] = bubble;
         pipe[1] = bubble;
      end else if (!hold) begin
         pipe[1] = '{wreg: pipe[0].wreg, rw: pipe[0].rw, mr: 1'b0};
         pipe[0] = ex_flush ? bubble : '{wreg: ex_wreg, rw: ex_regwrite, mr: ex_memread};
      end
   endtask

   task automatic check_all();
      chk("fwd_a",        fwd_a,          ref_fwd(ex_rs));
      chk("fwd_b",        fwd_b,          ref_fwd(ex_rt));
      chk("stall",        load_use_stall, ref_stall());
      chk("mem_wreg",     mem_wreg,       pipe[0].wreg);
      chk("mem_regwrite", mem_regwrite,   pipe[0].rw);
      chk("mem_memread",  mem_memread,    pipe[0].mr);
      chk("wb_wreg",      wb_wreg,        pipe[1].wreg);
      chk("wb_regwrite",  wb_regwrite,    pipe[1].rw);
   endtask

   // Inputs are set just after a falling edge; outputs are sampled 1 ns later.
   task automatic cycle(input bit do_chk);
      #1;
      if (do_chk) check_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      reset = 0; hold = 0; ex_flush = 0;
      id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0;
      ex_wreg = 0; ex_regwrite = 0; ex_memread = 0;
   endtask

   task automatic rand_ex();
      id_rs       = 5'($urandom_range(0, 7));
      id_rt       = 5'($urandom_range(0, 7));
      ex_rs       = 5'($urandom_range(0, 7));
      ex_rt       = 5'($urandom_range(0, 7));
      ex_wreg     = 5'($urandom_range(0, 7));
      ex_regwrite = 1'($urandom_range(0, 1));
      ex_memread  = 1'($urandom_range(0, 3) == 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      stage_t z;
      z = '0;
      pipe[0] = z;
      pipe[1] = z;
      idle_inputs();
      reset = 1;
      @(negedge clk);

      // Reset for two cycles with arbitrary inputs
      for (int i = 0; i < 2; i++) begin
         rand_ex();
         hold = 1'($urandom_range(0, 1));
         ex_flush = 1'($urandom_range(0, 1));
         reset = 1;
         cycle(1'b0);
      end
      idle_inputs();
      #1;
      chk("rst_fwd_a", fwd_a, 2'b00);
      chk("rst_fwd_b", fwd_b, 2'b00);
      chk("rst_stall", load_use_stall, 1'b0);
      chk("rst_mem", {mem_wreg, mem_regwrite, mem_memread}, 7'd0);
      chk("rst_wb", {wb_wreg, wb_regwrite}, 6'd0);
      cycle(1'b1);

      // Back-to-back forward
      ex_wreg = 8; ex_regwrite = 1; ex_rs = 1; ex_rt = 2;
      cycle(1'b1);
      ex_wreg = 3; ex_rs = 8; ex_rt = 8;
      #1;
      chk("b2b_fwd_a_mem", fwd_a, 2'b10);
      chk("b2b_fwd_b_mem", fwd_b, 2'b10);
      cycle(1'b1);
      ex_wreg = 4; ex_rs = 8; ex_rt = 0;
      #1;
      chk("b2b_fwd_a_wb", fwd_a, 2'b01);
      chk("b2b_fwd_b_zero", fwd_b, 2'b00);
      cycle(1'b1);

      // Double hazard on $9
      ex_wreg = 9; ex_regwrite = 1; ex_rs = 0; ex_rt = 0;
      cycle(1'b1);
      cycle(1'b1);
      ex_rs = 9; ex_wreg = 2;
      #1;
      chk("dbl_fwd_a", fwd_a, 2'b10);
      cycle(1'b1);

      // Load-use, then bubble, then dependent sees load in WB
      idle_inputs();
      ex_memread = 1; ex_regwrite = 1; ex_wreg = 10; id_rt = 10; id_rs = 3;
      #1;
      chk("lu_stall", load_use_stall, 1'b1);
      cycle(1'b1);
      idle_inputs();
      cycle(1'b1);
      ex_rs = 10;
      #1;
      chk("lu_fwd_wb", fwd_a, 2'b01);
      cycle(1'b1);
      idle_inputs();
      ex_memread = 1; ex_regwrite = 1; ex_wreg = 0; id_rt = 0; id_rs = 0;
      #1;
      chk("lu_zero_nostall", load_use_stall, 1'b0);
      cycle(1'b1);

      // Hold freezes both stages; a flush during hold is not latched
      idle_inputs();
      ex_wreg = 5; ex_regwrite = 1;
      cycle(1'b1);
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         ex_wreg = 5'($urandom_range(11, 20));
         ex_flush = (i == 2);
         cycle(1'b1);
         chk("hold_mem_wreg", mem_wreg, 5'd5);
         chk("hold_wb_wreg", wb_wreg, 5'd8 - 5'd8 + pipe[1].wreg);
      end
      hold = 0; ex_flush = 0; ex_wreg = 12;
      cycle(1'b1);
      chk("rel_wb_wreg", wb_wreg, 5'd5);
      chk("rel_mem_wreg", mem_wreg, 5'd12);

      // Flush and register 0
      ex_flush = 1; ex_wreg = 7; ex_regwrite = 1;
      cycle(1'b1);
      chk("flush_mem_rw", mem_regwrite, 1'b0);
      chk("flush_mem_wreg", mem_wreg, 5'd0);
      ex_flush = 0; ex_wreg = 0; ex_regwrite = 1;
      cycle(1'b1);
      ex_rs = 0;
      #1;
      chk("zero_fwd_a", fwd_a, 2'b00);
      cycle(1'b1);

      // Randomized traffic with occasional hold, flush and mid-run reset
      for (int n = 0; n < 400; n++) begin
         rand_ex();
         hold     = 1'($urandom_range(0, 4) == 0);
         ex_flush = 1'($urandom_range(0, 6) == 0);
         reset    = 1'($urandom_range(0, 40) == 0);
         cycle(1'b1);
      end
      idle_inputs();
      cycle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
